// File: rtl/car_pkg.sv
// car_pkg: shared types and command field positions for the car drive controller.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package car_pkg;

  typedef enum logic [1:0] {
    OP_DRIVE  = 2'b00,
    OP_CRUISE = 2'b01,
    OP_SELECT = 2'b10,
    OP_AUTO   = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'd0,
    MODE_LINE   = 2'd1,
    MODE_WANDER = 2'd2,
    MODE_STOP   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    SUB_LINE   = 2'd0,
    SUB_WANDER = 2'd1,
    SUB_STOP   = 2'd2
  } submode_e;

  typedef enum logic [1:0] {
    MOT_STOP = 2'd0,
    MOT_FWD  = 2'd1,
    MOT_REV  = 2'd2
  } motion_e;

  // Command byte field positions
  localparam int OP_HI     = 7;
  localparam int OP_LO     = 6;
  localparam int CRUISE_HI = 5;
  localparam int CRUISE_LO = 0;
  localparam int STEER_HI  = 3;
  localparam int STEER_LO  = 2;
  localparam int MOT_HI    = 1;
  localparam int MOT_LO    = 0;
  localparam int SUB_HI    = 1;
  localparam int SUB_LO    = 0;

  // Submode field: 00 line, 01 wander, anything else stop
  function automatic submode_e decode_submode(input logic [1:0] f);
    case (f)
      2'b00:   return SUB_LINE;
      2'b01:   return SUB_WANDER;
      default: return SUB_STOP;
    endcase
  endfunction

  function automatic mode_e auto_mode(input submode_e s);
    case (s)
      SUB_LINE:   return MODE_LINE;
      SUB_WANDER: return MODE_WANDER;
      default:    return MODE_STOP;
    endcase
  endfunction

endpackage

// File: rtl/speed_ramp.sv
// speed_ramp: slews motor speed toward the target, with reversal interlock through zero speed.
// Latency: CAR_DRIVE_RAMP_EN defined -> 1 unit per RAMP_DIV cycles; undefined -> speed follows target next cycle.
// Backpressure: none; target is sampled every cycle.
module speed_ramp #(
  parameter int SPD_W    = 8,
  parameter int RAMP_DIV = 500_000
) (
  input  logic             clk_50M,
  input  logic             rst,
  input  logic [SPD_W-1:0] tgt,
  input  logic             req_dir,
  output logic [SPD_W-1:0] speed,
  output logic             direction
);

  if (RAMP_DIV < 1) begin : g_bad_ramp_div
    $error("RAMP_DIV must be at least 1");
  end

  logic [SPD_W-1:0] speed_q, speed_d;
  logic [SPD_W-1:0] eff_tgt;
  logic             dir_q, dir_d;

  // Direction may only change once the motor is already at standstill
  always_comb begin
    dir_d = dir_q;
    if ((req_dir != dir_q) && (speed_q == '0)) dir_d = req_dir;
  end

`ifdef CAR_DRIVE_RAMP_EN
  localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;

  // Free-running divider producing one slew tick every RAMP_DIV cycles
  always_comb begin
    tick  = (div_q == DIV_W'(RAMP_DIV - 1));
    div_d = tick ? '0 : div_q + DIV_W'(1);
  end

  // Step one unit toward the target on each tick; a pending reversal targets zero
  always_comb begin
    eff_tgt = (req_dir != dir_q) ? '0 : tgt;
    speed_d = speed_q;
    if (tick) begin
      if (speed_q < eff_tgt)      speed_d = speed_q + SPD_W'(1);
      else if (speed_q > eff_tgt) speed_d = speed_q - SPD_W'(1);
    end
  end

  // Divider register
  always_ff @(posedge clk_50M) begin
    if (rst) div_q <= '0;
    else     div_q <= div_d;
  end
`else
  // Jump straight to target; judged against the next direction so speed resumes as it flips
  always_comb begin
    eff_tgt = (req_dir != dir_d) ? '0 : tgt;
    speed_d = eff_tgt;
  end
`endif

  // Speed and direction registers
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      speed_q <= '0;
      dir_q   <= 1'b1;
    end else begin
      speed_q <= speed_d;
      dir_q   <= dir_d;
    end
  end

  assign speed     = speed_q;
  assign direction = dir_q;

endmodule

// File: rtl/car_drive_ctrl.sv
// car_drive_ctrl: command decode, mode FSM, link watchdog and obstacle gating ahead of speed_ramp.
// Latency: mode/degree/target register 1 cycle after cmd_valid; speed slews when CAR_DRIVE_RAMP_EN is defined.
// Backpressure: none; every cmd_valid strobe is accepted in the cycle it arrives.
module car_drive_ctrl #(
  parameter int SPD_W      = 8,
  parameter int DEG_W      = 9,
  parameter int DIST_W     = 8,
  parameter int DEG_CENTER = 95,
  parameter int DEG_LEFT   = 120,
  parameter int DEG_RIGHT  = 60,
  parameter int STOP_DIST  = 20,
  parameter int WDOG_CYC   = 25_000_000,
  parameter int RAMP_DIV   = 500_000
) (
  input  logic              clk_50M,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [7:0]        cmd_data,
  input  logic [DIST_W-1:0] forward_dist,
  input  logic [DIST_W-1:0] back_dist,
  input  logic [1:0]        line_ir,
  output logic [SPD_W-1:0]  speed,
  output logic [DEG_W-1:0]  degree,
  output logic              direction,
  output logic              beep_en,
  output logic [1:0]        mode,
  output logic              link_lost
);
  import car_pkg::*;

  if (SPD_W < 6) begin : g_bad_spd_w
    $error("SPD_W must be at least 6 to hold the cruise field");
  end

  localparam int                WD_W    = $clog2(WDOG_CYC + 1);
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(WDOG_CYC - 1);
  localparam logic [DEG_W-1:0]  DEG_C   = DEG_W'(DEG_CENTER);
  localparam logic [DEG_W-1:0]  DEG_L   = DEG_W'(DEG_LEFT);
  localparam logic [DEG_W-1:0]  DEG_R   = DEG_W'(DEG_RIGHT);
  localparam logic [DIST_W-1:0] STOP_D  = DIST_W'(STOP_DIST);

  mode_e            mode_q, mode_d;
  submode_e         submode_q, submode_d;
  motion_e          motion_q, motion_d;
  logic [SPD_W-1:0] cruise_q, cruise_d;
  logic [DEG_W-1:0] degree_q, degree_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic             link_lost_q, link_lost_d;

  opcode_e          opcode;
  logic             drive_cmd;
  logic [SPD_W-1:0] tgt;
  logic             req_dir;

  assign opcode    = opcode_e'(cmd_data[OP_HI:OP_LO]);
  assign drive_cmd = cmd_valid && (opcode == OP_DRIVE);

  // Mode FSM next state plus cruise, submode and manual motion updates
  always_comb begin
    mode_d    = mode_q;
    submode_d = submode_q;
    cruise_d  = cruise_q;
    motion_d  = motion_q;
    if (cmd_valid) begin
      case (opcode)
        OP_DRIVE: begin
          mode_d = MODE_MANUAL;
          case (cmd_data[MOT_HI:MOT_LO])
            2'b01:   motion_d = MOT_FWD;
            2'b10:   motion_d = MOT_REV;
            default: motion_d = MOT_STOP;
          endcase
        end
        OP_CRUISE: cruise_d = SPD_W'(cmd_data[CRUISE_HI:CRUISE_LO]);
        OP_SELECT: begin
          submode_d = decode_submode(cmd_data[SUB_HI:SUB_LO]);
          if (mode_q != MODE_MANUAL) mode_d = auto_mode(submode_d);
        end
        default: mode_d = auto_mode(submode_q);
      endcase
    end
  end

  // Steering follows the mode being entered so it lands in the same cycle as mode
  always_comb begin
    degree_d = degree_q;
    case (mode_d)
      MODE_MANUAL: begin
        if (drive_cmd) begin
          case (cmd_data[STEER_HI:STEER_LO])
            2'b01:   degree_d = DEG_R;
            2'b10:   degree_d = DEG_L;
            default: degree_d = DEG_C;
          endcase
        end
      end
      MODE_LINE: begin
        case (line_ir)
          2'b10:   degree_d = DEG_L;
          2'b01:   degree_d = DEG_R;
          default: degree_d = DEG_C;
        endcase
      end
      default: degree_d = DEG_C;
    endcase
  end

  // Manual link watchdog; a command arriving in the expiry cycle keeps the link alive
  always_comb begin
    wdog_d      = wdog_q;
    link_lost_d = link_lost_q;
    if ((mode_q != MODE_MANUAL) || cmd_valid) begin
      wdog_d      = '0;
      link_lost_d = 1'b0;
    end else if (wdog_q == WD_LAST) begin
      link_lost_d = 1'b1;
    end else begin
      wdog_d = wdog_q + WD_W'(1);
    end
  end

  // Requested direction and speed target, gated by link loss and obstacles
  always_comb begin
    req_dir = direction;
    tgt     = '0;
    case (mode_q)
      MODE_MANUAL: begin
        if (motion_q == MOT_FWD) begin
          req_dir = 1'b1;
          tgt     = cruise_q;
        end else if (motion_q == MOT_REV) begin
          req_dir = 1'b0;
          tgt     = cruise_q;
        end
        if (link_lost_q) tgt = '0;
      end
      MODE_LINE: begin
        req_dir = 1'b1;
        if (line_ir != 2'b11) tgt = cruise_q;
      end
      MODE_WANDER: begin
        req_dir = 1'b1;
        tgt     = cruise_q;
      end
      default: ;
    endcase
    if (req_dir && (forward_dist <= STOP_D)) tgt = '0;
    if (!req_dir && (back_dist <= STOP_D))   tgt = '0;
  end

  // State registers
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      mode_q      <= MODE_MANUAL;
      submode_q   <= SUB_LINE;
      motion_q    <= MOT_STOP;
      cruise_q    <= SPD_W'(15);
      degree_q    <= DEG_C;
      wdog_q      <= '0;
      link_lost_q <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      submode_q   <= submode_d;
      motion_q    <= motion_d;
      cruise_q    <= cruise_d;
      degree_q    <= degree_d;
      wdog_q      <= wdog_d;
      link_lost_q <= link_lost_d;
    end
  end

  speed_ramp #(
    .SPD_W    (SPD_W),
    .RAMP_DIV (RAMP_DIV)
  ) u_speed_ramp (
    .clk_50M   (clk_50M),
    .rst       (rst),
    .tgt       (tgt),
    .req_dir   (req_dir),
    .speed     (speed),
    .direction (direction)
  );

  assign beep_en   = !direction && (speed != '0);
  assign mode      = mode_q;
  assign degree    = degree_q;
  assign link_lost = link_lost_q;

endmodule

// File: tb/tb_car_drive_ctrl.sv
// tb_car_drive_ctrl: directed-vector bench for car_drive_ctrl (RAMP_DIV=4, WDOG_CYC=100).
// Latency: expectations follow CAR_DRIVE_RAMP_EN when defined, jump-to-target otherwise.
// Backpressure: not applicable.
module tb_car_drive_ctrl;

  logic       clk_50M = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic [7:0] forward_dist = 8'd200;
  logic [7:0] back_dist = 8'd200;
  logic [1:0] line_ir = 2'b00;
  logic [7:0] speed;
  logic [8:0] degree;
  logic       direction;
  logic       beep_en;
  logic [1:0] mode;
  logic       link_lost;

  int checks = 0;
  int failures = 0;

  always #10 clk_50M = ~clk_50M;

  car_drive_ctrl #(
    .WDOG_CYC (100),
    .RAMP_DIV (4)
  ) dut (
    .clk_50M      (clk_50M),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_data     (cmd_data),
    .forward_dist (forward_dist),
    .back_dist    (back_dist),
    .line_ir      (line_ir),
    .speed        (speed),
    .degree       (degree),
    .direction    (direction),
    .beep_en      (beep_en),
    .mode         (mode),
    .link_lost    (link_lost)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk_50M);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    cmd_valid = 1'b1;
    cmd_data  = b;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_speed(input string tag, input int v, input int budget);
    int n = 0;
    while (int'(speed) != v && n < budget) begin
      step();
      n++;
    end
    check(tag, int'(speed), v);
  endtask

  initial begin
    int n;

    // Reset state
    step(); step(); step();
    check("rst_speed", speed, 0);
    check("rst_degree", degree, 95);
    check("rst_direction", direction, 1);
    check("rst_beep", beep_en, 0);
    check("rst_mode", mode, 0);
    check("rst_link_lost", link_lost, 0);
    rst = 1'b0;

    // Cruise 1, forward
    send(8'h41);
    send(8'h01);
    wait_speed("fwd_speed1", 1, 4);
    check("fwd_direction", direction, 1);
    check("fwd_degree", degree, 95);

    // Cruise 10, forward + right
    send(8'h4A);
    send(8'h05);
    check("right_degree", degree, 60);
`ifdef CAR_DRIVE_RAMP_EN
    wait_speed("ramp_speed3", 3, 12);
    n = 0;
    while (speed == 8'd3 && n < 10) begin
      step();
      n++;
    end
    check("ramp_step_period", n, 4);
    check("ramp_step_size", speed, 4);
`endif
    wait_speed("ramp_to10", 10, 45);

    // Reverse: through zero, flip, back up to cruise
    send(8'h02);
    wait_speed("rev_down0", 0, 45);
    check("rev_dir_hold", direction, 1);
    step();
    check("rev_dir_flip", direction, 0);
`ifdef CAR_DRIVE_RAMP_EN
    check("rev_beep_off", beep_en, 0);
    send(8'h02);
    wait_speed("rev_up1", 1, 6);
    check("rev_beep_on", beep_en, 1);
    wait_speed("rev_up10", 10, 45);
`else
    check("rev_speed10", speed, 10);
    check("rev_beep_on", beep_en, 1);
`endif

    // Back to forward, then front obstacle at exactly the threshold
    send(8'h01);
    wait_speed("fwd_again_down0", 0, 45);
    step();
    check("fwd_again_dir", direction, 1);
    send(8'h01);
    wait_speed("fwd_again_10", 10, 45);
    back_dist = 8'd5;
    forward_dist = 8'd20;
    wait_speed("obst_stop", 0, 45);
    check("obst_dir_kept", direction, 1);
    check("obst_degree_kept", degree, 95);
    send(8'h01);
    forward_dist = 8'd21;
    wait_speed("obst_clear", 10, 45);
    back_dist = 8'd200;
    forward_dist = 8'd200;

    // Watchdog expiry after 100 idle cycles
    send(8'h01);
    n = 0;
    while (!link_lost && n < 120) begin
      step();
      n++;
    end
    check("wdog_cycles", n, 100);
    wait_speed("wdog_stop", 0, 45);
    send(8'h01);
    check("wdog_restored", link_lost, 0);
    repeat (99) step();
    send(8'h01);
    check("wdog_cmd_on_expiry", link_lost, 0);
    step();
    check("wdog_still_ok", link_lost, 0);

    // Auto modes
    send(8'h80);
    check("select_in_manual", mode, 0);
    send(8'hC0);
    check("mode_line", mode, 1);
    line_ir = 2'b10;
    step();
    check("line_left", degree, 120);
    line_ir = 2'b11;
    step();
    check("line_both_center", degree, 95);
    wait_speed("line_both_stop", 0, 45);
    repeat (110) step();
    check("auto_no_wdog", link_lost, 0);
    line_ir = 2'b01;
    step();
    check("line_right", degree, 60);
    send(8'h81);
    check("mode_wander", mode, 2);
    check("wander_center", degree, 95);
    send(8'h82);
    check("mode_stop", mode, 3);

    // Reset mid-motion, then default cruise of 15
    send(8'h01);
    n = 0;
    while (speed == 8'd0 && n < 45) begin
      step();
      n++;
    end
    check("pre_rst_moving", int'(speed != 8'd0), 1);
    rst = 1'b1;
    step();
    check("midrst_speed", speed, 0);
    check("midrst_mode", mode, 0);
    check("midrst_direction", direction, 1);
    rst = 1'b0;
    send(8'h01);
    wait_speed("default_cruise15", 15, 70);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
